gb_mbc_mapper: RTL and testbench
================================

Name: gb_mbc_mapper

Overview:
Parametrised Game Boy cartridge memory-bank controller that replaces the fixed ROM-only MBC1 bank switcher. It supports full MBC1 (RAM enable, 2-bit upper bank, banking mode) and MBC5 (9-bit ROM bank, 4-bit RAM bank), selected by parameter. The cartridge bus is sampled in the fast internal clock domain, and one register commit is generated per bus write. The block emits mapped external ROM/RAM addresses and strobes; the memories themselves sit outside the block.

Parameters:
MAPPER, 0, 0 = MBC1, 1 = MBC5
ROM_AW, 19, external ROM byte-address width (bank bits = ROM_AW-14, max 23)
RAM_AW, 15, external RAM byte-address width (bank bits = RAM_AW-13, max 17)
SYNC_STAGES, 2, synchroniser depth for wr (>=2)
LED_CYCLES, 1000000, green activity-LED hold time in clk cycles

Ports:
clk  in  1  internal clock; all logic is on its rising edge
rst  in  1  synchronous reset, active-low
wr  in  1  cartridge write strobe, active-low, asynchronous to clk
rd  in  1  cartridge read strobe, active-low
cs  in  1  cartridge RAM chip select, active-low
addr  in  16  cartridge address bus
data_in  in  8  cartridge data bus, GB->FPGA
rom_addr  out  ROM_AW  mapped ROM byte address
rom_oe  out  1  ROM read enable
ram_addr  out  RAM_AW  mapped RAM byte address
ram_oe  out  1  RAM read enable
ram_we  out  1  one-cycle RAM write pulse
ram_wdata  out  8  RAM write data
data_dir  out  1  1 = FPGA->GB drive, 0 = GB->FPGA
status_led  out  3  {r,g,b}

Behaviour:
- Write detect: wr passes through a SYNC_STAGES flop chain. The chain resets to 0 (asserted), so a write that straddles reset release never commits. A commit pulse fires for one cycle when the synchronised wr goes 1->0. addr and data_in are sampled in the commit cycle. A strobe held low for many cycles produces exactly one commit.
- Register writes on commit, MBC1 (addr decode):
  - 0x0000-0x1FFF: ram_en <= (data_in[3:0] == 4'hA).
  - 0x2000-0x3FFF: bank_lo <= data_in[4:0]. If data_in[4:0] is 0, store 1.
  - 0x4000-0x5FFF: bank_hi <= data_in[1:0].
  - 0x6000-0x7FFF: mode <= data_in[0].
- Register writes on commit, MBC5:
  - 0x0000-0x1FFF: ram_en as in MBC1.
  - 0x2000-0x2FFF: rom_bank[7:0] <= data_in.
  - 0x3000-0x3FFF: rom_bank[8] <= data_in[0].
  - 0x4000-0x5FFF: ram_bank <= data_in[3:0].
  - Bank 0 is legal; there is no 0->1 remap.
- Reset values:
  - Registers: ram_en 0, bank_lo 1, bank_hi 0, mode 0, rom_bank 1, ram_bank 0.
  - Outputs: ram_we 0, ram_wdata 0, status_led 0, LED counter 0.
- A register write is visible on the mapped outputs the cycle after its commit.
- ROM mapping, combinational; the bank is truncated to ROM_AW-14 bits (wraps modulo ROM size):
  - MBC1, 0x0000-0x3FFF: bank = mode ? {bank_hi,5'b0} : 0.
  - MBC1, 0x4000-0x7FFF: bank = {bank_hi,bank_lo}.
  - MBC5, 0x0000-0x3FFF: bank 0.
  - MBC5, 0x4000-0x7FFF: bank = rom_bank.
  - rom_addr = {bank, addr[13:0]}.
- RAM mapping: ram_addr = {bank, addr[12:0]}, with the bank truncated to RAM_AW-13 bits.
  - MBC1: bank = mode ? bank_hi : 0.
  - MBC5: bank = ram_bank.
- Strobes and direction:
  - rom_oe = !rd && !addr[15].
  - ram_oe = !rd && !cs && ram_en && addr in 0xA000-0xBFFF.
  - data_dir = rom_oe | ram_oe.
  - With RAM disabled, the bus is never driven for 0xA000-0xBFFF.
- RAM write: a commit with addr in 0xA000-0xBFFF, cs low and ram_en 1 registers ram_we = 1 for exactly one cycle, with ram_wdata = the sampled data. Otherwise ram_we = 0.
- Simultaneous events: reset has priority over a commit. A commit and the LED counter reload share a cycle without conflict.
- status_led:
  - r = ram_en.
  - g = 1 while the activity counter is nonzero; any commit reloads it to LED_CYCLES-1, and it decrements to 0.
  - b = mode (MBC1) or rom_bank[8] (MBC5).

Test Plan:
- MBC1 bank switch: write 0x00 to 0x2100, then read 0x4123. Required: bank_lo = 1, rom_addr = 0x04123. Then write 0x13 and read 0x4000. Required: rom_addr = 0x4C000.
- MBC1 mode 1 with ROM_AW = 21: write 0x02 to 0x4000 and 0x01 to 0x6000, then read 0x0010. Required: rom_addr = 0x100010, b = 1. With RAM enabled, A000 maps to ram_addr 0x4000.
- Long strobe and sync: wr held low for 40 cycles. Required: exactly one commit; the register updates 1 cycle after the commit; ram_we is high for exactly 1 cycle on a valid A-range write.
- RAM gating: write 0x0B to 0x0000, then read 0xA000 with cs low. Required: ram_oe = 0, data_dir = 0, no ram_we. Then write 0x0A. Required: ram_oe = 1, r = 1.
- MBC5: write 0x00 to 0x2000 and 0x01 to 0x3000 with ROM_AW = 23, then read 0x4005. Required: rom_addr = 0x400005. Writing 0x00 to 0x3000 then gives bank 0, rom_addr = 0x0005.
- Reset mid-operation: set all registers non-default, then assert rst with wr held low across its release. Required: every register returns to its reset value and no commit occurs; g = 0 after reset.

Source files
------------

// File: rtl/gb_mbc_mapper.sv
// Game Boy cartridge bank controller (MBC1 or MBC5 by MAPPER) running in the fast clk domain.
// Each synchronised falling edge of wr commits one register write; mapped addresses and strobes are combinational.
module gb_mbc_mapper #(
    parameter int MAPPER      = 0,
    parameter int ROM_AW      = 19,
    parameter int RAM_AW      = 15,
    parameter int SYNC_STAGES = 2,
    parameter int LED_CYCLES  = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic              cs,
    input  logic [15:0]       addr,
    input  logic [7:0]        data_in,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_oe,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_oe,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    output logic              data_dir,
    output logic [2:0]        status_led
);

    localparam int ROM_BW = ROM_AW - 14;
    localparam int RAM_BW = RAM_AW - 13;
    localparam int LED_W  = (LED_CYCLES > 1) ? $clog2(LED_CYCLES) : 1;
    localparam logic [LED_W-1:0] LED_RELOAD = LED_W'(LED_CYCLES - 1);

    logic [SYNC_STAGES-1:0] wrSync_q;
    logic                   wrPrev_q;
    logic                   commit;
    logic                   inRamWin;

    logic       ramEn_q,   ramEn_d;
    logic [4:0] bankLo_q,  bankLo_d;
    logic [1:0] bankHi_q,  bankHi_d;
    logic       mode_q,    mode_d;
    logic [8:0] romBank_q, romBank_d;
    logic [3:0] ramBank_q, ramBank_d;
    logic       ramWe_q,   ramWe_d;
    logic [7:0] ramWdata_q, ramWdata_d;
    logic [LED_W-1:0] ledCnt_q, ledCnt_d;

    logic [ROM_BW-1:0] romBankSel;
    logic [RAM_BW-1:0] ramBankSel;

    // Chain resets to the asserted level so a strobe straddling reset release never looks like a new edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrSync_q <= '0;
            wrPrev_q <= 1'b0;
        end else begin
            wrSync_q <= {wrSync_q[SYNC_STAGES-2:0], wr};
            wrPrev_q <= wrSync_q[SYNC_STAGES-1];
        end
    end

    assign commit   = wrPrev_q & ~wrSync_q[SYNC_STAGES-1];
    assign inRamWin = (addr[15:13] == 3'b101);

    always_comb begin
        ramEn_d    = ramEn_q;
        bankLo_d   = bankLo_q;
        bankHi_d   = bankHi_q;
        mode_d     = mode_q;
        romBank_d  = romBank_q;
        ramBank_d  = ramBank_q;
        ramWe_d    = commit && inRamWin && !cs && ramEn_q;
        ramWdata_d = ramWe_d ? data_in : ramWdata_q;
        ledCnt_d   = (ledCnt_q != '0) ? ledCnt_q - 1'b1 : ledCnt_q;
        if (commit) begin
            ledCnt_d = LED_RELOAD;
            if (MAPPER == 0) begin
                case (addr[15:13])
                    3'b000:  ramEn_d  = (data_in[3:0] == 4'hA);
                    3'b001:  bankLo_d = (data_in[4:0] == 5'd0) ? 5'd1 : data_in[4:0];
                    3'b010:  bankHi_d = data_in[1:0];
                    3'b011:  mode_d   = data_in[0];
                    default: ;
                endcase
            end else begin
                case (addr[15:12])
                    4'h0, 4'h1: ramEn_d        = (data_in[3:0] == 4'hA);
                    4'h2:       romBank_d[7:0] = data_in;
                    4'h3:       romBank_d[8]   = data_in[0];
                    4'h4, 4'h5: ramBank_d      = data_in[3:0];
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ramEn_q    <= 1'b0;
            bankLo_q   <= 5'd1;
            bankHi_q   <= 2'd0;
            mode_q     <= 1'b0;
            romBank_q  <= 9'd1;
            ramBank_q  <= 4'd0;
            ramWe_q    <= 1'b0;
            ramWdata_q <= 8'd0;
            ledCnt_q   <= '0;
        end else begin
            ramEn_q    <= ramEn_d;
            bankLo_q   <= bankLo_d;
            bankHi_q   <= bankHi_d;
            mode_q     <= mode_d;
            romBank_q  <= romBank_d;
            ramBank_q  <= ramBank_d;
            ramWe_q    <= ramWe_d;
            ramWdata_q <= ramWdata_d;
            ledCnt_q   <= ledCnt_d;
        end
    end

    // Bank numbers are cast down to the physical memory size, so oversized banks wrap.
    always_comb begin
        if (MAPPER == 0) begin
            if (addr[14]) begin
                romBankSel = ROM_BW'({bankHi_q, bankLo_q});
            end else begin
                romBankSel = mode_q ? ROM_BW'({bankHi_q, 5'b00000}) : '0;
            end
            ramBankSel = mode_q ? RAM_BW'(bankHi_q) : '0;
        end else begin
            romBankSel = addr[14] ? ROM_BW'(romBank_q) : '0;
            ramBankSel = RAM_BW'(ramBank_q);
        end
    end

    assign rom_addr   = {romBankSel, addr[13:0]};
    assign ram_addr   = {ramBankSel, addr[12:0]};
    assign rom_oe     = !rd && !addr[15];
    assign ram_oe     = !rd && !cs && ramEn_q && inRamWin;
    assign data_dir   = rom_oe | ram_oe;
    assign ram_we     = ramWe_q;
    assign ram_wdata  = ramWdata_q;
    assign status_led = {ramEn_q, (ledCnt_q != '0), (MAPPER == 0) ? mode_q : romBank_q[8]};

endmodule

// File: tb/tb_gb_mbc_mapper.sv
// Directed bench for gb_mbc_mapper: MBC1 (two ROM sizes) and MBC5 instances share one cartridge bus.
module tb_gb_mbc_mapper;

    logic        clk = 1'b0;
    logic        rst, wr, rd, cs;
    logic [15:0] addr;
    logic [7:0]  data_in;

    logic [20:0] u1RomAddr;  logic u1RomOe;  logic [14:0] u1RamAddr; logic u1RamOe; logic u1RamWe;
    logic [7:0]  u1RamWdata; logic u1DataDir; logic [2:0] u1Led;
    logic [18:0] usRomAddr;  logic usRomOe;  logic [14:0] usRamAddr; logic usRamOe; logic usRamWe;
    logic [7:0]  usRamWdata; logic usDataDir; logic [2:0] usLed;
    logic [22:0] u5RomAddr;  logic u5RomOe;  logic [16:0] u5RamAddr; logic u5RamOe; logic u5RamWe;
    logic [7:0]  u5RamWdata; logic u5DataDir; logic [2:0] u5Led;

    int checkCount = 0;
    int passCount  = 0;
    int weCount    = 0;

    always #5 clk = ~clk;

    gb_mbc_mapper #(.MAPPER(0), .ROM_AW(21), .RAM_AW(15), .SYNC_STAGES(2), .LED_CYCLES(8)) u1 (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .cs(cs), .addr(addr), .data_in(data_in),
        .rom_addr(u1RomAddr), .rom_oe(u1RomOe), .ram_addr(u1RamAddr), .ram_oe(u1RamOe),
        .ram_we(u1RamWe), .ram_wdata(u1RamWdata), .data_dir(u1DataDir), .status_led(u1Led));

    gb_mbc_mapper #(.MAPPER(0), .ROM_AW(19), .RAM_AW(15), .SYNC_STAGES(2), .LED_CYCLES(8)) us (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .cs(cs), .addr(addr), .data_in(data_in),
        .rom_addr(usRomAddr), .rom_oe(usRomOe), .ram_addr(usRamAddr), .ram_oe(usRamOe),
        .ram_we(usRamWe), .ram_wdata(usRamWdata), .data_dir(usDataDir), .status_led(usLed));

    gb_mbc_mapper #(.MAPPER(1), .ROM_AW(23), .RAM_AW(17), .SYNC_STAGES(2), .LED_CYCLES(8)) u5 (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .cs(cs), .addr(addr), .data_in(data_in),
        .rom_addr(u5RomAddr), .rom_oe(u5RomOe), .ram_addr(u5RamAddr), .ram_oe(u5RamOe),
        .ram_we(u5RamWe), .ram_wdata(u5RamWdata), .data_dir(u5DataDir), .status_led(u5Led));

    always @(negedge clk) begin
        if (u1RamWe === 1'b1) weCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [15:0] a, input logic [7:0] d, input logic csv, input int hold);
        tick();
        rd = 1'b1;
        addr = a;
        data_in = d;
        cs = csv;
        wr = 1'b0;
        repeat (hold) tick();
        wr = 1'b1;
        repeat (4) tick();
        cs = 1'b1;
    endtask

    task automatic readAt(input logic [15:0] a, input logic csv);
        addr = a;
        cs = csv;
        rd = 1'b0;
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr = 1'b1; rd = 1'b1; cs = 1'b1; addr = 16'h0000; data_in = 8'h00;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        if (u1Led !== 3'b000) begin $display("FAIL reset_led: got %b expected %b", u1Led, 3'b000); end else passCount++;
        checkCount++;
        if (u1RamWe !== 1'b0 || u1RamWdata !== 8'h00) begin $display("FAIL reset_ramwr: got we=%b wdata=%h expected we=0 wdata=00", u1RamWe, u1RamWdata); end else passCount++;
        checkCount++;
        readAt(16'h4123, 1'b1);
        if (u1RomAddr !== 21'h004123) begin $display("FAIL reset_mbc1_bank1: got %h expected %h", u1RomAddr, 21'h004123); end else passCount++;
        checkCount++;
        if (u5RomAddr !== 23'h004123) begin $display("FAIL reset_mbc5_bank1: got %h expected %h", u5RomAddr, 23'h004123); end else passCount++;
        checkCount++;
        if (u1RomOe !== 1'b1 || u1DataDir !== 1'b1) begin $display("FAIL reset_rom_oe: got oe=%b dir=%b expected 1 1", u1RomOe, u1DataDir); end else passCount++;
        checkCount++;
        rd = 1'b1;
    endtask

    task automatic test_mbc1_bank();
        busWrite(16'h2100, 8'h00, 1'b1, 3);
        if (u1Led[1] !== 1'b1) begin $display("FAIL led_green_on: got %b expected 1", u1Led[1]); end else passCount++;
        checkCount++;
        readAt(16'h4123, 1'b1);
        if (u1RomAddr !== 21'h004123) begin $display("FAIL mbc1_zero_remap: got %h expected %h", u1RomAddr, 21'h004123); end else passCount++;
        checkCount++;
        if (u5RomAddr !== 23'h000123) begin $display("FAIL mbc5_bank0_legal: got %h expected %h", u5RomAddr, 23'h000123); end else passCount++;
        checkCount++;
        busWrite(16'h2100, 8'h13, 1'b1, 3);
        readAt(16'h4000, 1'b1);
        if (u1RomAddr !== 21'h04C000) begin $display("FAIL mbc1_bank13: got %h expected %h", u1RomAddr, 21'h04C000); end else passCount++;
        checkCount++;
        if (usRomAddr !== 19'h4C000) begin $display("FAIL mbc1s_bank13: got %h expected %h", usRomAddr, 19'h4C000); end else passCount++;
        checkCount++;
        rd = 1'b1;
        repeat (10) tick();
        if (u1Led[1] !== 1'b0) begin $display("FAIL led_green_expire: got %b expected 0", u1Led[1]); end else passCount++;
        checkCount++;
    endtask

    task automatic test_ram_gating();
        busWrite(16'h0000, 8'h0B, 1'b1, 3);
        readAt(16'hA000, 1'b0);
        if (u1RamOe !== 1'b0 || u1DataDir !== 1'b0) begin $display("FAIL ram_disabled_oe: got oe=%b dir=%b expected 0 0", u1RamOe, u1DataDir); end else passCount++;
        checkCount++;
        rd = 1'b1;
        weCount = 0;
        busWrite(16'hA010, 8'h77, 1'b0, 3);
        if (weCount !== 0) begin $display("FAIL ram_disabled_we: got %0d pulses expected 0", weCount); end else passCount++;
        checkCount++;
        busWrite(16'h0000, 8'h0A, 1'b1, 3);
        readAt(16'hA000, 1'b0);
        if (u1RamOe !== 1'b1 || u1DataDir !== 1'b1) begin $display("FAIL ram_enabled_oe: got oe=%b dir=%b expected 1 1", u1RamOe, u1DataDir); end else passCount++;
        checkCount++;
        if (u1Led[2] !== 1'b1) begin $display("FAIL ram_led_red: got %b expected 1", u1Led[2]); end else passCount++;
        checkCount++;
        rd = 1'b1; cs = 1'b1;
    endtask

    task automatic test_long_strobe();
        tick();
        weCount = 0;
        addr = 16'hA123; data_in = 8'h5A; cs = 1'b0; rd = 1'b1; wr = 1'b0;
        tick(); tick();
        if (u1RamWe !== 1'b0) begin $display("FAIL strobe_we_early: got %b expected 0", u1RamWe); end else passCount++;
        checkCount++;
        tick();
        if (u1RamWe !== 1'b1 || u1RamWdata !== 8'h5A) begin $display("FAIL strobe_we_pulse: got we=%b wdata=%h expected 1 5a", u1RamWe, u1RamWdata); end else passCount++;
        checkCount++;
        if (u5RamWe !== 1'b1) begin $display("FAIL strobe_we_mbc5: got %b expected 1", u5RamWe); end else passCount++;
        checkCount++;
        tick();
        if (u1RamWe !== 1'b0) begin $display("FAIL strobe_we_width: got %b expected 0", u1RamWe); end else passCount++;
        checkCount++;
        repeat (36) tick();
        wr = 1'b1;
        repeat (4) tick();
        cs = 1'b1;
        if (weCount !== 1) begin $display("FAIL strobe_single_commit: got %0d pulses expected 1", weCount); end else passCount++;
        checkCount++;
    endtask

    task automatic test_mbc1_mode();
        busWrite(16'h4000, 8'h02, 1'b1, 3);
        tick();
        addr = 16'h6000; data_in = 8'h01; wr = 1'b0;
        tick(); tick();
        if (u1Led[0] !== 1'b0) begin $display("FAIL mode_not_yet: got %b expected 0", u1Led[0]); end else passCount++;
        checkCount++;
        tick();
        if (u1Led[0] !== 1'b1) begin $display("FAIL mode_visible: got %b expected 1", u1Led[0]); end else passCount++;
        checkCount++;
        wr = 1'b1;
        repeat (4) tick();
        readAt(16'h0010, 1'b1);
        if (u1RomAddr !== 21'h100010) begin $display("FAIL mode1_low_rom: got %h expected %h", u1RomAddr, 21'h100010); end else passCount++;
        checkCount++;
        if (usRomAddr !== 19'h00010) begin $display("FAIL mode1_low_wrap: got %h expected %h", usRomAddr, 19'h00010); end else passCount++;
        checkCount++;
        readAt(16'h4000, 1'b1);
        if (u1RomAddr !== 21'h14C000) begin $display("FAIL mode1_high_rom: got %h expected %h", u1RomAddr, 21'h14C000); end else passCount++;
        checkCount++;
        if (usRomAddr !== 19'h4C000) begin $display("FAIL mode1_high_wrap: got %h expected %h", usRomAddr, 19'h4C000); end else passCount++;
        checkCount++;
        readAt(16'hA000, 1'b0);
        if (u1RamAddr !== 15'h4000 || u1RamOe !== 1'b1) begin $display("FAIL mode1_ram: got addr=%h oe=%b expected 4000 1", u1RamAddr, u1RamOe); end else passCount++;
        checkCount++;
        if (u5RamAddr !== 17'h04000) begin $display("FAIL mbc5_ram_bank2: got %h expected %h", u5RamAddr, 17'h04000); end else passCount++;
        checkCount++;
        rd = 1'b1; cs = 1'b1;
    endtask

    task automatic test_mbc5();
        busWrite(16'h2000, 8'h00, 1'b1, 3);
        busWrite(16'h3000, 8'h01, 1'b1, 3);
        readAt(16'h4005, 1'b1);
        if (u5RomAddr !== 23'h400005) begin $display("FAIL mbc5_bank100: got %h expected %h", u5RomAddr, 23'h400005); end else passCount++;
        checkCount++;
        if (u5Led[0] !== 1'b1) begin $display("FAIL mbc5_led_blue: got %b expected 1", u5Led[0]); end else passCount++;
        checkCount++;
        if (u1RomAddr !== 21'h104005) begin $display("FAIL mbc1_bank41: got %h expected %h", u1RomAddr, 21'h104005); end else passCount++;
        checkCount++;
        busWrite(16'h3000, 8'h00, 1'b1, 3);
        readAt(16'h4005, 1'b1);
        if (u5RomAddr !== 23'h000005) begin $display("FAIL mbc5_bank0: got %h expected %h", u5RomAddr, 23'h000005); end else passCount++;
        checkCount++;
        busWrite(16'h4000, 8'h0F, 1'b1, 3);
        readAt(16'hA000, 1'b0);
        if (u5RamAddr !== 17'h1E000) begin $display("FAIL mbc5_ram_bankF: got %h expected %h", u5RamAddr, 17'h1E000); end else passCount++;
        checkCount++;
        if (u1RamAddr !== 15'h6000) begin $display("FAIL mbc1_ram_bank3: got %h expected %h", u1RamAddr, 15'h6000); end else passCount++;
        checkCount++;
        rd = 1'b1; cs = 1'b1;
    endtask

    task automatic test_reset_mid();
        tick();
        addr = 16'h2000; data_in = 8'h05; cs = 1'b1; rd = 1'b1;
        wr = 1'b0; rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        if (u1Led !== 3'b000 || u5Led !== 3'b000) begin $display("FAIL rstmid_led: got %b %b expected 000 000", u1Led, u5Led); end else passCount++;
        checkCount++;
        repeat (10) tick();
        wr = 1'b1;
        repeat (4) tick();
        readAt(16'h4005, 1'b1);
        if (u1RomAddr !== 21'h004005) begin $display("FAIL rstmid_mbc1_rom: got %h expected %h", u1RomAddr, 21'h004005); end else passCount++;
        checkCount++;
        if (u5RomAddr !== 23'h004005) begin $display("FAIL rstmid_mbc5_rom: got %h expected %h", u5RomAddr, 23'h004005); end else passCount++;
        checkCount++;
        readAt(16'h0010, 1'b1);
        if (u1RomAddr !== 21'h000010) begin $display("FAIL rstmid_mode: got %h expected %h", u1RomAddr, 21'h000010); end else passCount++;
        checkCount++;
        readAt(16'hA000, 1'b0);
        if (u1RamOe !== 1'b0 || u1RamAddr !== 15'h0000 || u5RamAddr !== 17'h00000) begin $display("FAIL rstmid_ram: got oe=%b a1=%h a5=%h expected 0 0000 00000", u1RamOe, u1RamAddr, u5RamAddr); end else passCount++;
        checkCount++;
        if (u1RamWdata !== 8'h00 || u1Led !== 3'b000) begin $display("FAIL rstmid_outputs: got wdata=%h led=%b expected 00 000", u1RamWdata, u1Led); end else passCount++;
        checkCount++;
        rd = 1'b1; cs = 1'b1;
    endtask

    initial begin
        test_reset();
        test_mbc1_bank();
        test_ram_gating();
        test_long_strobe();
        test_mbc1_mode();
        test_mbc5();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
